cpu_control_unit: RTL and testbench

- Multi-cycle instruction sequencer for the Salamander-4 core.
- Drives the ALU: CE, OP_CODE, operand selects and carry-in.
- Consumes the ALU's result and carry, and holds the Z/C flags.
- Fetches from instruction memory over a req/ack handshake, executes HLT/JMP/RTN/NOP itself, and owns the PC and the return stack.

---
 rtl/salamander_pkg.sv | 60 ++++++
 rtl/cu_return_stack.sv | 49 ++++
 rtl/cpu_control_unit.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/salamander_pkg.sv
// Shared definitions for the Salamander-4 control unit: opcodes, FSM state
// encodings, jump conditions and instruction field positions.
package salamander_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_LD  = 4'h6,
    OP_ST  = 4'h7,
    OP_INC = 4'h8,
    OP_DEC = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_HLT = 4'hC,
    OP_JMP = 4'hD,
    OP_RTN = 4'hE,
    OP_NOP = 4'hF
  } opcode_e;

  // Sequencer states
  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;

  // JMP condition field (shares the dst bits)
  localparam logic [1:0] JC_ALWAYS = 2'b00;
  localparam logic [1:0] JC_ZERO   = 2'b01;
  localparam logic [1:0] JC_CARRY  = 2'b10;
  localparam logic [1:0] JC_CALL   = 2'b11;

  // LD takes its right operand from the immediate when src is this value
  localparam logic [1:0] SRC_IMM = 2'b11;

  // Instruction field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 10;
  localparam int SRC_MSB = 9;
  localparam int SRC_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes whose writeback refreshes the zero flag
  function automatic logic updates_zero(opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
  endfunction

  // Opcodes that consume and refresh the carry flag
  function automatic logic updates_carry(opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cu_return_stack.sv
// Return-address LIFO for CALL/RTN. The write pointer wraps modulo DEPTH, so
// an overflowing push overwrites the oldest entry and an underflowing pop
// reads the entry at the wrapped pointer. full/empty come from a saturating
// occupancy count so the caller can refuse pushes/pops if it wants to.
module cu_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] sp;
  logic [PTR_W:0]   count;
  logic [W-1:0]     mem [DEPTH];

  assign pop_data = mem[sp - PTR_W'(1)];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp    <= sp + PTR_W'(1);
      count <= full ? count : count + (PTR_W + 1)'(1);
    end else if (pop) begin
      sp    <= sp - PTR_W'(1);
      count <= empty ? count : count - (PTR_W + 1)'(1);
    end
  end

  // Entry storage; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Salamander-4 multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// plus HALT. Owns the PC, the Z/C flags and the return stack; drives the ALU.
// Optional build macro CU_STACK_GUARD_EN: CALL on a full stack or RTN on an
// empty stack halts the core and raises a sticky stack_err output.
module cpu_control_unit
  import salamander_pkg::*;
#(
  parameter int SIZE        = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              alu_ce,
  output logic [3:0]        alu_op_code,
  output logic              alu_carry_in,
  input  logic [SIZE-1:0]   alu_result,
  input  logic              alu_carry_out,
  output logic [1:0]        rf_raddr_a,
  output logic [1:0]        rf_raddr_b,
  output logic              opnd_imm_sel,
  output logic [SIZE-1:0]   opnd_imm,
  output logic [1:0]        rf_waddr,
  output logic              rf_we,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
`ifdef CU_STACK_GUARD_EN
  ,
  output logic              stack_err
`endif
);

  logic [2:0]        state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [15:0]       instr;
  logic [SIZE-1:0]   result_q;
  logic              carry_q;

  opcode_e           op;
  logic [1:0]        dst, src;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] pc_inc, target;
  logic              fetch_ack;

  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_data;

`ifdef CU_STACK_GUARD_EN
  logic              err_set;
`else
  logic              stack_flags_unused;
  assign stack_flags_unused = stk_full | stk_empty;
`endif

  assign op        = opcode_e'(instr[OPC_MSB:OPC_LSB]);
  assign dst       = instr[DST_MSB:DST_LSB];
  assign src       = instr[SRC_MSB:SRC_LSB];
  assign imm       = instr[IMM_MSB:IMM_LSB];
  assign pc_inc    = pc + ADDR_W'(1);
  assign target    = ADDR_W'(imm);
  assign fetch_ack = (state == ST_FETCH) && imem_req && imem_ack;
  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  cu_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .pop_data  (stk_data),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next state, next PC and stack operations; control flow resolves in DECODE
  always_comb begin
    state_next = state;
    pc_next    = pc;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
`ifdef CU_STACK_GUARD_EN
    err_set    = 1'b0;
`endif
    case (state)
      ST_FETCH: if (fetch_ack) state_next = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_HLT: state_next = ST_HALT;
          OP_NOP: begin
            pc_next    = pc_inc;
            state_next = ST_FETCH;
          end
          OP_JMP: begin
            state_next = ST_FETCH;
            case (dst)
              JC_ALWAYS: pc_next = target;
              JC_ZERO:   pc_next = flag_z ? target : pc_inc;
              JC_CARRY:  pc_next = flag_c ? target : pc_inc;
              default: begin
`ifdef CU_STACK_GUARD_EN
                if (stk_full) begin
                  state_next = ST_HALT;
                  err_set    = 1'b1;
                end else
`endif
                begin
                  stk_push = 1'b1;
                  pc_next  = target;
                end
              end
            endcase
          end
          OP_RTN: begin
`ifdef CU_STACK_GUARD_EN
            if (stk_empty) begin
              state_next = ST_HALT;
              err_set    = 1'b1;
            end else
`endif
            begin
              stk_pop    = 1'b1;
              pc_next    = stk_data;
              state_next = ST_FETCH;
            end
          end
          default: state_next = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: state_next = ST_WRITEBACK;
      ST_WRITEBACK: begin
        pc_next    = pc_inc;
        state_next = ST_FETCH;
      end
      default: state_next = ST_HALT;
    endcase
  end

  // Control state: FSM, PC, fetch request and flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_FETCH;
      pc       <= '0;
      imem_req <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
`ifdef CU_STACK_GUARD_EN
      stack_err <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      // Request is raised on entry to FETCH and dropped on the accepting edge
      imem_req <= (state_next == ST_FETCH);
      if (state == ST_WRITEBACK) begin
        if (updates_zero(op))  flag_z <= (result_q == '0);
        if (updates_carry(op)) flag_c <= carry_q;
      end
`ifdef CU_STACK_GUARD_EN
      if (err_set) stack_err <= 1'b1;
`endif
    end
  end

  // Datapath captures: instruction word on fetch, ALU outputs on execute
  always_ff @(posedge CLK) begin
    if (fetch_ack) instr <= imem_rdata;
    if (state == ST_EXECUTE) begin
      result_q <= alu_result;
      carry_q  <= alu_carry_out;
    end
  end

  // ALU and register-file strobes; everything is zero outside its own state
  always_comb begin
    alu_ce       = 1'b0;
    alu_op_code  = 4'h0;
    alu_carry_in = 1'b0;
    rf_raddr_a   = 2'b00;
    rf_raddr_b   = 2'b00;
    opnd_imm_sel = 1'b0;
    opnd_imm     = '0;
    rf_we        = 1'b0;
    rf_waddr     = 2'b00;
    case (state)
      ST_EXECUTE: begin
        alu_ce       = 1'b1;
        alu_op_code  = op;
        alu_carry_in = updates_carry(op) ? flag_c : 1'b0;
        rf_raddr_a   = dst;
        rf_raddr_b   = src;
        opnd_imm_sel = (op == OP_LD) && (src == SRC_IMM);
        opnd_imm     = SIZE'(imm);
      end
      ST_WRITEBACK: begin
        rf_we    = (op != OP_ST);
        rf_waddr = dst;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: plays instruction memory and ALU,
// walks reset, ALU ops, flags, jumps, calls/returns, stack overflow and halt.
module tb_cpu_control_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        alu_ce;
  logic [3:0]  alu_op_code;
  logic        alu_carry_in;
  logic [7:0]  alu_result;
  logic        alu_carry_out;
  logic [1:0]  rf_raddr_a, rf_raddr_b;
  logic        opnd_imm_sel;
  logic [7:0]  opnd_imm;
  logic [1:0]  rf_waddr;
  logic        rf_we;
  logic        flag_z, flag_c, halted;
  logic [7:0]  pc;
`ifdef CU_STACK_GUARD_EN
  logic        stack_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  cpu_control_unit dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .alu_ce        (alu_ce),
    .alu_op_code   (alu_op_code),
    .alu_carry_in  (alu_carry_in),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .rf_raddr_a    (rf_raddr_a),
    .rf_raddr_b    (rf_raddr_b),
    .opnd_imm_sel  (opnd_imm_sel),
    .opnd_imm      (opnd_imm),
    .rf_waddr      (rf_waddr),
    .rf_we         (rf_we),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .halted        (halted),
    .pc            (pc)
`ifdef CU_STACK_GUARD_EN
    ,
    .stack_err     (stack_err)
`endif
  );

  typedef struct packed {
    logic [7:0] fa;
    logic       ce;
    logic [3:0] op;
    logic       cin;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       isel;
    logic [7:0] imm;
    logic       we;
    logic [1:0] wa;
    logic       stray;
    logic       req_mid;
    logic [7:0] pc_after;
    logic       req_after;
  } alu_obs_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for a request, stall 'waits' cycles, then return 'word'
  task automatic fetch(input logic [15:0] word, input int waits, output logic [7:0] addr);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (imem_req === 1'b1) seen = 1;
      else tick();
    end
    addr = imem_addr;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL fetch_timeout: no imem_req seen for word %h", word);
    end
    repeat (waits) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  // Fetch and run one ALU instruction, recording what the DUT drove
  task automatic run_alu(input logic [15:0] word, input int waits, input logic [7:0] res,
                         input logic cout, output alu_obs_t o);
    fetch(word, waits, o.fa);
    o.stray   = alu_ce | rf_we;
    o.req_mid = imem_req;
    tick();
    o.ce   = alu_ce;
    o.op   = alu_op_code;
    o.cin  = alu_carry_in;
    o.ra   = rf_raddr_a;
    o.rb   = rf_raddr_b;
    o.isel = opnd_imm_sel;
    o.imm  = opnd_imm;
    o.stray   = o.stray | rf_we;
    o.req_mid = o.req_mid | imem_req;
    alu_result    = res;
    alu_carry_out = cout;
    tick();
    alu_result    = 8'h5A;
    alu_carry_out = ~cout;
    o.we      = rf_we;
    o.wa      = rf_waddr;
    o.stray   = o.stray | alu_ce;
    o.req_mid = o.req_mid | imem_req;
    tick();
    o.pc_after  = pc;
    o.req_after = imem_req;
  endtask

  // Fetch and run a control-flow instruction resolved in DECODE
  task automatic run_ctrl(input logic [15:0] word, output logic [7:0] fa,
                          output logic stray, output logic [7:0] pc_after);
    fetch(word, 0, fa);
    stray = alu_ce | rf_we;
    tick();
    stray    = stray | alu_ce | rf_we;
    pc_after = pc;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) tick();
    checks++;
    if ({imem_req, alu_ce, rf_we, flag_z, flag_c, halted} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000000",
               {imem_req, alu_ce, rf_we, flag_z, flag_c, halted});
    end
    checks++;
    if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
`ifdef CU_STACK_GUARD_EN
    checks++;
    if (stack_err !== 1'b0) begin failures++; $display("FAIL reset_stack_err got=%b exp=0", stack_err); end
`endif
    RST_N = 1'b1;
  endtask

  task automatic test_add_basic();
    alu_obs_t o;
    run_alu(16'h0612, 3, 8'h05, 1'b0, o);
    checks++;
    if (o.fa !== 8'h00) begin failures++; $display("FAIL add_fetch_addr got=%h exp=00", o.fa); end
    checks++;
    if ({o.ce, o.op} !== 5'h10) begin failures++; $display("FAIL add_ce_op got=%h exp=10", {o.ce, o.op}); end
    checks++;
    if ({o.ra, o.rb, o.isel, o.cin} !== 6'b011000) begin
      failures++; $display("FAIL add_operands got=%b exp=011000", {o.ra, o.rb, o.isel, o.cin});
    end
    checks++;
    if ({o.we, o.wa} !== 3'b101) begin failures++; $display("FAIL add_wb got=%b exp=101", {o.we, o.wa}); end
    checks++;
    if ({o.stray, o.req_mid, o.req_after} !== 3'b001) begin
      failures++; $display("FAIL add_timing got=%b exp=001", {o.stray, o.req_mid, o.req_after});
    end
    checks++;
    if (o.pc_after !== 8'h01) begin failures++; $display("FAIL add_pc got=%h exp=01", o.pc_after); end
    checks++;
    if ({flag_z, flag_c} !== 2'b00) begin failures++; $display("FAIL add_flags got=%b exp=00", {flag_z, flag_c}); end
  endtask

  task automatic test_flags();
    alu_obs_t o;
    run_alu(16'h0612, 0, 8'h00, 1'b1, o);
    checks++;
    if ({flag_z, flag_c} !== 2'b11) begin failures++; $display("FAIL flags_add_zero got=%b exp=11", {flag_z, flag_c}); end
    run_alu(16'h1612, 0, 8'h00, 1'b1, o);
    checks++;
    if ({o.op, o.cin} !== 5'b00011) begin failures++; $display("FAIL sub_carry_in got=%b exp=00011", {o.op, o.cin}); end
    run_alu(16'h2612, 0, 8'h05, 1'b0, o);
    checks++;
    if ({o.op, o.cin} !== 5'b00100) begin failures++; $display("FAIL and_carry_in got=%b exp=00100", {o.op, o.cin}); end
    checks++;
    if ({flag_z, flag_c} !== 2'b11) begin failures++; $display("FAIL and_keeps_flags got=%b exp=11", {flag_z, flag_c}); end
    run_alu(16'h8400, 0, 8'h01, 1'b0, o);
    checks++;
    if ({flag_z, flag_c} !== 2'b01) begin failures++; $display("FAIL inc_flags got=%b exp=01", {flag_z, flag_c}); end
    checks++;
    if (o.pc_after !== 8'h05) begin failures++; $display("FAIL flags_pc got=%h exp=05", o.pc_after); end
  endtask

  task automatic test_call_rtn();
    logic [7:0] fa, pcv;
    logic       stray;
    run_ctrl(16'hDC20, fa, stray, pcv);
    checks++;
    if ({fa, pcv, stray} !== {8'h05, 8'h20, 1'b0}) begin
      failures++; $display("FAIL call_at_5 got=%h/%h/%b exp=05/20/0", fa, pcv, stray);
    end
    run_ctrl(16'hE000, fa, stray, pcv);
    checks++;
    if ({fa, pcv} !== {8'h20, 8'h06}) begin failures++; $display("FAIL rtn_to_6 got=%h/%h exp=20/06", fa, pcv); end
  endtask

  task automatic test_jmp();
    logic [7:0] fa, pcv;
    logic       stray;
    alu_obs_t   o;
    run_ctrl(16'hD440, fa, stray, pcv);
    checks++;
    if ({pcv, stray} !== {8'h07, 1'b0}) begin failures++; $display("FAIL jz_not_taken got=%h/%b exp=07/0", pcv, stray); end
    run_alu(16'h0612, 0, 8'h00, 1'b0, o);
    checks++;
    if ({flag_z, flag_c} !== 2'b10) begin failures++; $display("FAIL add_set_z got=%b exp=10", {flag_z, flag_c}); end
    run_ctrl(16'hD440, fa, stray, pcv);
    checks++;
    if ({fa, pcv, stray} !== {8'h08, 8'h40, 1'b0}) begin
      failures++; $display("FAIL jz_taken got=%h/%h/%b exp=08/40/0", fa, pcv, stray);
    end
    run_ctrl(16'hD850, fa, stray, pcv);
    checks++;
    if (pcv !== 8'h41) begin failures++; $display("FAIL jc_not_taken got=%h exp=41", pcv); end
    run_ctrl(16'hD010, fa, stray, pcv);
    checks++;
    if (pcv !== 8'h10) begin failures++; $display("FAIL jmp_always got=%h exp=10", pcv); end
  endtask

  task automatic test_ld_st_nop();
    logic [7:0] fa, pcv;
    logic       stray;
    alu_obs_t   o;
    run_alu(16'h6BA5, 0, 8'hA5, 1'b1, o);
    checks++;
    if ({o.op, o.ra, o.rb, o.isel, o.imm} !== {4'h6, 2'b10, 2'b11, 1'b1, 8'hA5}) begin
      failures++; $display("FAIL ld_imm got=%h/%b/%b/%b/%h exp=6/10/11/1/a5", o.op, o.ra, o.rb, o.isel, o.imm);
    end
    checks++;
    if ({o.we, o.wa, flag_z, flag_c} !== 5'b11010) begin
      failures++; $display("FAIL ld_wb_flags got=%b exp=11010", {o.we, o.wa, flag_z, flag_c});
    end
    run_alu(16'h61A5, 0, 8'h00, 1'b0, o);
    checks++;
    if ({o.isel, o.rb} !== 3'b001) begin failures++; $display("FAIL ld_reg_sel got=%b exp=001", {o.isel, o.rb}); end
    run_alu(16'h7400, 0, 8'h00, 1'b0, o);
    checks++;
    if ({o.ce, o.we, o.pc_after} !== {2'b10, 8'h13}) begin
      failures++; $display("FAIL st_no_we got=%b/%h exp=10/13", {o.ce, o.we}, o.pc_after);
    end
    run_ctrl(16'hF000, fa, stray, pcv);
    checks++;
    if ({pcv, stray} !== {8'h14, 1'b0}) begin failures++; $display("FAIL nop got=%h/%b exp=14/0", pcv, stray); end
  endtask

  task automatic test_nested();
    logic [7:0] fa, pcv;
    logic       stray;
    logic [7:0] tgt [4] = '{8'h30, 8'h40, 8'h50, 8'h60};
    logic [7:0] ret [4] = '{8'h51, 8'h41, 8'h31, 8'h15};
    for (int i = 0; i < 4; i++) begin
      run_ctrl({8'hDC, tgt[i]}, fa, stray, pcv);
      checks++;
      if (pcv !== tgt[i]) begin failures++; $display("FAIL nest_call%0d got=%h exp=%h", i, pcv, tgt[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      run_ctrl(16'hE000, fa, stray, pcv);
      checks++;
      if (pcv !== ret[i]) begin failures++; $display("FAIL nest_rtn%0d got=%h exp=%h", i, pcv, ret[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] fa, pcv;
    logic       stray;
    logic [7:0] tgt [4] = '{8'h70, 8'h80, 8'h90, 8'hA0};
    for (int i = 0; i < 4; i++) run_ctrl({8'hDC, tgt[i]}, fa, stray, pcv);
    checks++;
    if (pcv !== 8'hA0) begin failures++; $display("FAIL ovf_setup got=%h exp=a0", pcv); end
`ifdef CU_STACK_GUARD_EN
    run_ctrl(16'hDCB0, fa, stray, pcv);
    checks++;
    if ({halted, stack_err, imem_req, pcv} !== {3'b110, 8'hA0}) begin
      failures++; $display("FAIL ovf_guard got=%b/%h exp=110/a0", {halted, stack_err, imem_req}, pcv);
    end
`else
    begin
      logic [7:0] ret [5] = '{8'hA1, 8'h91, 8'h81, 8'h71, 8'hA1};
      run_ctrl(16'hDCB0, fa, stray, pcv);
      checks++;
      if (pcv !== 8'hB0) begin failures++; $display("FAIL ovf_call got=%h exp=b0", pcv); end
      for (int i = 0; i < 5; i++) begin
        run_ctrl(16'hE000, fa, stray, pcv);
        checks++;
        if (pcv !== ret[i]) begin failures++; $display("FAIL ovf_rtn%0d got=%h exp=%h", i, pcv, ret[i]); end
      end
    end
`endif
  endtask

  task automatic test_halt_reset();
    logic [7:0] fa;
    logic       seen;
    alu_obs_t   o;
    RST_N = 1'b0;
    tick();
    checks++;
    if ({pc, halted} !== 9'h000) begin failures++; $display("FAIL rst2_state got=%h/%b exp=00/0", pc, halted); end
`ifdef CU_STACK_GUARD_EN
    checks++;
    if (stack_err !== 1'b0) begin failures++; $display("FAIL rst2_stack_err got=%b exp=0", stack_err); end
`endif
    RST_N = 1'b1;
    fetch(16'hC000, 1, fa);
    tick();
    checks++;
    if ({fa, halted} !== {8'h00, 1'b1}) begin failures++; $display("FAIL hlt got=%h/%b exp=00/1", fa, halted); end
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | imem_req | alu_ce | rf_we | ~halted;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL hlt_quiet got=%b exp=0", seen); end
    RST_N = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL hlt_reset got=%b exp=0", halted); end
    tick();
    RST_N = 1'b1;
    fetch(16'h0612, 0, fa);
    tick();
    checks++;
    if (alu_ce !== 1'b1) begin failures++; $display("FAIL mid_exec_ce got=%b exp=1", alu_ce); end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({imem_req, alu_ce, rf_we, halted, pc} !== 12'h000) begin
      failures++; $display("FAIL mid_exec_reset got=%b/%h exp=0000/00", {imem_req, alu_ce, rf_we, halted}, pc);
    end
    seen = 1'b0;
    repeat (2) begin
      tick();
      seen = seen | rf_we | alu_ce;
    end
    RST_N = 1'b1;
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_exec_no_wb got=%b exp=0", seen); end
    run_alu(16'h0612, 0, 8'h03, 1'b0, o);
    checks++;
    if ({o.fa, o.we, o.pc_after} !== {8'h00, 1'b1, 8'h01}) begin
      failures++; $display("FAIL restart got=%h/%b/%h exp=00/1/01", o.fa, o.we, o.pc_after);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST_N         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 16'h0000;
    alu_result    = 8'h00;
    alu_carry_out = 1'b0;
    test_reset();
    test_add_basic();
    test_flags();
    test_call_rtn();
    test_jmp();
    test_ld_st_nop();
    test_nested();
    test_overflow();
    test_halt_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
